// File: rtl/entropy_ac_run_level_scheduler.sv
// entropy_ac_run_level_scheduler: scans AC coefficients idx-major across blocks and emits run/level pairs.
// Optional ENTROPY_AC_SCHED_STATS_EN adds the pair_count output.
module entropy_ac_run_level_scheduler (
`ifdef ENTROPY_AC_SCHED_STATS_EN
   output logic        [9:0]  pair_count,
`endif
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic        [3:0]  num_blocks,
   output logic               coeff_rd_en,
   output logic        [8:0]  coeff_addr,
   input  logic signed [19:0] coeff_rd_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic        [8:0]  out_run,
   output logic signed [19:0] out_level,
   output logic               out_last,
   output logic               busy,
   output logic               done
);
   typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_EMIT, S_FLUSH, S_DONE} state_t;
   state_t r_state, w_next;
   logic        [2:0]  r_n, r_blk, w_n;
   logic        [5:0]  r_idx;
   logic        [8:0]  r_run, r_pend_run;
   logic signed [19:0] r_pend_level, r_hold;
   logic               r_pend_valid, w_nz, w_wrap, w_last, w_adv, w_flush_out;
   // r_n holds N-1 so the block wrap compare stays 3 bits wide
   assign w_n         = num_blocks == 4'd0 ? 3'd0 : (num_blocks[3] ? 3'd7 : num_blocks[2:0] - 3'd1);
   assign w_nz        = coeff_rd_data != 20'sd0;
   assign w_wrap      = r_blk == r_n;
   assign w_last      = w_wrap && r_idx == 6'd63;
   assign w_flush_out = r_state == S_FLUSH && r_pend_valid;
   assign w_adv       = (r_state == S_CAPTURE && !(w_nz && r_pend_valid)) || (r_state == S_EMIT && out_ready);
   assign coeff_rd_en = r_state == S_READ;
   assign coeff_addr  = coeff_rd_en ? {r_blk, r_idx} : 9'd0;
   assign out_valid   = r_state == S_EMIT || w_flush_out;
   assign out_run     = out_valid ? r_pend_run : 9'd0;
   assign out_level   = out_valid ? r_pend_level : 20'sd0;
   assign out_last    = w_flush_out;
   assign busy        = r_state != S_IDLE;
   assign done        = r_state == S_DONE;
   always_ff @(posedge clk)
      r_state <= reset ? S_IDLE : w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    w_next = start ? S_READ : S_IDLE;
         S_READ:    w_next = S_CAPTURE;
         S_CAPTURE: w_next = (w_nz && r_pend_valid) ? S_EMIT : (w_last ? S_FLUSH : S_READ);
         S_EMIT:    w_next = out_ready ? (w_last ? S_FLUSH : S_READ) : S_EMIT;
         S_FLUSH:   w_next = (!r_pend_valid || out_ready) ? S_DONE : S_FLUSH;
         default:   w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_n          <= 3'd0;
         r_blk        <= 3'd0;
         r_idx        <= 6'd0;
         r_run        <= 9'd0;
         r_pend_run   <= 9'd0;
         r_pend_level <= 20'sd0;
         r_hold       <= 20'sd0;
         r_pend_valid <= 1'b0;
      end else begin
         if (r_state == S_IDLE && start) begin
            r_n          <= w_n;
            r_idx        <= 6'd1;
            r_blk        <= 3'd0;
            r_run        <= 9'd0;
            r_pend_valid <= 1'b0;
         end
         if (w_adv) begin
            r_blk <= w_wrap ? 3'd0 : r_blk + 3'd1;
            if (w_wrap) r_idx <= r_idx + 6'd1;
         end
         if (r_state == S_CAPTURE) begin
            if (!w_nz) r_run <= r_run + 9'd1;
            else if (!r_pend_valid) begin
               r_pend_run   <= r_run;
               r_pend_level <= coeff_rd_data;
               r_pend_valid <= 1'b1;
               r_run        <= 9'd0;
            end else r_hold <= coeff_rd_data;
         end
         // run is frozen during EMIT, so it still belongs to the held coefficient
         if (r_state == S_EMIT && out_ready) begin
            r_pend_run   <= r_run;
            r_pend_level <= r_hold;
            r_run        <= 9'd0;
         end
         if (r_state == S_FLUSH && out_ready) r_pend_valid <= 1'b0;
      end
   end
`ifdef ENTROPY_AC_SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (reset || (r_state == S_IDLE && start)) pair_count <= 10'd0;
      else if (out_valid && out_ready) pair_count <= pair_count + 10'd1;
   end
`endif
endmodule

// File: tb/tb_entropy_ac_run_level_scheduler.sv
// tb_entropy_ac_run_level_scheduler: scoreboard bench with a coefficient memory model and a reference scan.
module tb_entropy_ac_run_level_scheduler;
   typedef struct packed {logic [8:0] run; logic signed [19:0] level; logic last;} pair_t;
   logic               clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b1;
   logic        [3:0]  num_blocks = 4'd1;
   logic               coeff_rd_en, out_valid, out_last, busy, done;
   logic        [8:0]  coeff_addr, out_run;
   logic signed [19:0] coeff_rd_data = 20'sd0, out_level;
`ifdef ENTROPY_AC_SCHED_STATS_EN
   logic        [9:0]  pair_count;
`endif
   logic signed [19:0] mem [512];
   pair_t exp_q [$];
   pair_t prev_pair;
   bit    prev_stall = 0;
   int    n_chk = 0, n_err = 0, done_cnt = 0, n_pairs = 0, mode = 0, cyc = 0;

   entropy_ac_run_level_scheduler dut (
`ifdef ENTROPY_AC_SCHED_STATS_EN
      .pair_count(pair_count),
`endif
      .clk(clk), .reset(reset), .start(start), .num_blocks(num_blocks),
      .coeff_rd_en(coeff_rd_en), .coeff_addr(coeff_addr), .coeff_rd_data(coeff_rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_run(out_run), .out_level(out_level),
      .out_last(out_last), .busy(busy), .done(done));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clr(input logic signed [19:0] v);
      for (int i = 0; i < 512; i++) mem[i] = v;
   endtask

   task automatic build_exp(input int n);
      int    run;
      pair_t p;
      run = 0;
      exp_q.delete();
      for (int idx = 1; idx < 64; idx++)
         for (int blk = 0; blk < n; blk++)
            if (mem[blk * 64 + idx] == 20'sd0) run++;
            else begin
               p.run = 9'(run);
               p.level = mem[blk * 64 + idx];
               p.last = 1'b0;
               exp_q.push_back(p);
               run = 0;
            end
      if (exp_q.size() > 0) begin
         p = exp_q.pop_back();
         p.last = 1'b1;
         exp_q.push_back(p);
      end
      n_pairs = exp_q.size();
   endtask

   // coefficient buffer: data appears one cycle after the read strobe
   initial begin
      int a;
      forever begin
         @(negedge clk);
         if (coeff_rd_en) begin
            a = int'(coeff_addr);
            @(posedge clk);
            #1 coeff_rd_data = mem[a];
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1 out_ready = mode == 0 ? 1'b1 : (mode == 1 ? ~out_ready : 1'b0);
   end

   always @(negedge clk) begin
      if (reset) prev_stall = 0;
      else begin
         if (done) done_cnt++;
         if (prev_stall) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_hold", {2'd0, out_run, out_level, out_last}, {2'd0, prev_pair});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("extra_pair", 32'd1, 32'd0);
            else begin
               pair_t e;
               e = exp_q.pop_front();
               chk("run", {23'd0, out_run}, {23'd0, e.run});
               chk("level", 32'(out_level), 32'(e.level));
               chk("last", {31'd0, out_last}, {31'd0, e.last});
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_pair = {out_run, out_level, out_last};
      end
   end

   task automatic scan(input logic [3:0] nb, input bit poke);
      int n;
      n = nb == 0 ? 1 : (nb > 8 ? 8 : int'(nb));
      build_exp(n);
      done_cnt = 0;
      @(negedge clk);
      num_blocks = nb;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 5000) begin
         start = poke && (cyc == 20 || cyc == 21);
         num_blocks = start ? 4'd1 : nb;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk("done_seen", {31'd0, done}, 32'd1);
      @(negedge clk);
      chk("busy_after", {31'd0, busy}, 32'd0);
      chk("done_once", 32'(done_cnt), 32'd1);
      chk("q_empty", 32'(exp_q.size()), 32'd0);
`ifdef ENTROPY_AC_SCHED_STATS_EN
      chk("pair_count", {22'd0, pair_count}, 32'(n_pairs));
`endif
   endtask

   initial begin
      int w;
      clr(20'sd0);
      repeat (3) @(negedge clk);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_rd", {22'd0, coeff_rd_en, coeff_addr}, 32'd0);
      reset = 1'b0;
      mem[0] = 20'sd9; mem[1] = 20'sd5; mem[3] = -20'sd2;
      scan(4'd1, 0);
      clr(20'sd0);
      scan(4'd8, 0);
      chk("zero_cycles", 32'(cyc), 32'(8 * 63 * 2 + 2));
      mem[64 + 63] = -20'sd1;
      scan(4'd2, 0);
      chk("n2_pairs", 32'(n_pairs), 32'd1);
      clr(20'sd1);
      mem[0] = 20'sd7;
      mode = 1;
      scan(4'd4, 0);
      chk("n4_pairs", 32'(n_pairs), 32'd252);
      mode = 0;
      clr(20'sd0);
      for (int i = 0; i < 512; i += 37) mem[i] = 20'($urandom_range(1, 300)) - 20'sd150;
      scan(4'd0, 0);
      mode = 1;
      scan(4'd12, 1);
      mode = 2;
      clr(20'sd0);
      mem[1] = 20'sd3; mem[2] = 20'sd4;
      @(negedge clk);
      num_blocks = 4'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (!out_valid && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("stall_reached", {31'd0, out_valid}, 32'd1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_out", {2'd0, out_run, out_level, out_last}, 32'd0);
      chk("mid_rst_ctl", {28'd0, out_valid, busy, done, coeff_rd_en}, 32'd0);
      chk("mid_rst_addr", {23'd0, coeff_addr}, 32'd0);
      start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("start_in_rst", {31'd0, busy}, 32'd0);
      mode = 0;
      scan(4'd1, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/entropy_ac_run_level_scheduler.md
ENTROPY_AC_RUN_LEVEL_SCHEDULER -- requirements
Module: entropy_ac_run_level_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising clk edge.
REQ-002 clk  input  1  clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 start  input  1  one-cycle pulse beginning a slice scan; ignored while busy=1.
REQ-005 num_blocks  input  4  blocks in slice, sampled on accepted start; 0 treated as 1, 9..15 treated as 8.
REQ-006 coeff_rd_en  output  1  coefficient buffer read strobe.
REQ-007 coeff_addr  output  9  read address = blk*64 + idx (buffer already holds coefficients in scan order).
REQ-008 coeff_rd_data  input  signed 20  read data, valid exactly one cycle after coeff_rd_en.
REQ-009 out_valid / out_ready  output / input  1 / 1  run/level pair handshake toward the AC level encoder.
REQ-010 out_run  output  9  count of zero coefficients preceding out_level.
REQ-011 out_level  output  signed 20  nonzero coefficient, passed through unmodified.
REQ-012 out_last  output  1  marks final pair of the slice.
REQ-013 busy  output  1  high from accepted start until done.
REQ-014 done  output  1  one-cycle pulse at end of scan.

Function
REQ-015 Scan order SHALL be idx 1..63 outer, blk 0..N-1 inner (N = clamped num_blocks); DC (idx 0) is never read.
REQ-016 FSM states SHALL be IDLE, READ, CAPTURE, EMIT, FLUSH, DONE.
REQ-017 IDLE: on start, latch N, set idx=1, blk=0, run=0, pend_valid=0, busy=1, go READ.
REQ-018 READ: assert coeff_rd_en for exactly one cycle with coeff_addr, go CAPTURE.
REQ-019 CAPTURE: if data==0, run increments; if data!=0 and pend_valid=0, load pending pair (run, data), clear run; if data!=0 and pend_valid=1, hold data and go EMIT.
REQ-020 EMIT: present pending pair with out_valid=1, out_last=0; on out_valid&&out_ready, load held pair into pending, clear run, advance.
REQ-021 Advance: blk increments; at blk=N-1, blk=0 and idx increments; after (idx=63, blk=N-1) go FLUSH, else READ.
REQ-022 FLUSH: if pend_valid, present pending with out_valid=1, out_last=1 until accepted, then DONE; if no pair exists, go DONE directly (no pair emitted).
REQ-023 DONE: done=1 one cycle, busy=0 next cycle, return IDLE; trailing zero run SHALL be discarded.
REQ-024 out_run, out_level, out_last SHALL remain stable while out_valid=1 and out_ready=0; out_valid SHALL not drop before acceptance.
REQ-025 Run counter SHALL be 9 bits; max value 503 (8*63-1) SHALL not wrap.
REQ-026 With no stalls, each zero coefficient SHALL cost 2 cycles; each nonzero 2 cycles plus EMIT handshake cycles when a pair is pending.
REQ-027 out_valid SHALL be 0 in IDLE, READ, CAPTURE, DONE.

Reset
REQ-028 reset SHALL force IDLE and clear coeff_rd_en, coeff_addr, out_valid, out_run, out_level, out_last, busy, done, run, pend_valid to 0, including mid-scan and mid-handshake.
REQ-029 start asserted in the same cycle as reset SHALL be ignored.

Configuration
REQ-030 With ENTROPY_AC_SCHED_STATS_EN defined, output pair_count (10 bits) SHALL count accepted pairs, clear on accepted start and reset, and hold after done.
REQ-031 Without ENTROPY_AC_SCHED_STATS_EN, pair_count SHALL not exist and behaviour SHALL otherwise be identical.

Verification
REQ-032 N=1, coeffs idx1=5, idx3=-2, rest 0, out_ready=1 -> pairs (0,5,last=0),(1,-2,last=1), done once, pair_count=2.
REQ-033 N=8, all AC zero -> no out_valid, done after 8*63*2+ constant cycles, busy then 0.
REQ-034 N=2, blk1 idx63=-1 only -> single pair (125,-1,last=1).
REQ-035 N=4, every coefficient 1, out_ready toggling 1/0 -> 252 pairs, run=0 each, outputs stable during stalls, last only on 252nd.
REQ-036 reset asserted during EMIT stall -> next cycle all outputs 0, IDLE; subsequent start rescans from idx=1, blk=0.
REQ-037 num_blocks=0 and 12 -> scan behaves as N=1 and N=8 respectively; start during busy ignored.
